pool_stream: RTL and testbench

Streaming 2-D pooling unit between the systolic-array output path and the activation stage. It consumes one LANES-wide row vector per accepted beat. It reduces a k×k window, horizontally across adjacent lanes and vertically across k consecutive beats, in average or max mode, with valid/ready flow control on both sides. When disabled it is a zero-latency pass-through.

---
 rtl/pool_pkg.sv | 32 +++
 rtl/pool_window_reduce.sv | 41 ++++
 rtl/pool_stream.sv | 233 +++++++++++++++++++++++
 tb/tb_pool_stream.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared definitions for the streaming pooling unit.
//   - mode encodings POOL_AVG / POOL_MAX
//   - kernel_size codes K1 / K2 / K4 and the widest window KMAX
//   - k_log2(): kernel code -> log2(k); unsupported codes behave as k=1
//   - pool_state_e: IDLE / ACCUM / HOLD control states
package pool_pkg;

  localparam logic POOL_AVG = 1'b0;
  localparam logic POOL_MAX = 1'b1;

  localparam logic [2:0] K1 = 3'd1;
  localparam logic [2:0] K2 = 3'd2;
  localparam logic [2:0] K4 = 3'd4;

  // Widest horizontal window (lanes per reducer instance).
  localparam int KMAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pool_state_e;

  function automatic logic [1:0] k_log2(input logic [2:0] ks);
    case (ks)
      K2:      k_log2 = 2'd1;
      K4:      k_log2 = 2'd2;
      default: k_log2 = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pool_window_reduce.sv
// pool_window_reduce: combinational reduction of one horizontal window of
// up to KMAX lanes.
//   win_data  : KMAX lanes, lane i at [i*DWIDTH +: DWIDTH]
//   win_mask  : per-lane valid bits; a cleared bit makes that lane count as 0
//   mode      : POOL_AVG -> red_val is the sum, POOL_MAX -> red_val is the max
//   red_val   : sum or zero-extended max of the masked lanes
//   red_mask  : OR of win_mask
// Window lanes beyond the current k are supplied with their mask bit cleared,
// so they drop out of both the sum and the max.
module pool_window_reduce
  import pool_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic [KMAX*DWIDTH-1:0]          win_data,
  input  logic [KMAX-1:0]                 win_mask,
  input  logic                            mode,
  output logic [DWIDTH+$clog2(KMAX)-1:0]  red_val,
  output logic                            red_mask
);

  localparam int RW = DWIDTH + $clog2(KMAX);

  logic [RW-1:0]     sum;
  logic [DWIDTH-1:0] mx;
  logic [DWIDTH-1:0] v;

  always_comb begin
    sum = '0;
    mx  = '0;
    v   = '0;
    for (int i = 0; i < KMAX; i++) begin
      v   = win_mask[i] ? win_data[i*DWIDTH +: DWIDTH] : '0;
      sum = sum + RW'(v);
      if (v > mx) mx = v;
    end
    red_val  = (mode == POOL_MAX) ? RW'(mx) : sum;
    red_mask = |win_mask;
  end

endmodule

// File: rtl/pool_stream.sv
// pool_stream: streaming k x k pooling between the systolic-array output path
// and the activation stage.
//   clk, reset     : clock, synchronous active-high reset
//   enable_pool    : 0 = combinational pass-through, 1 = pooling
//   mode           : POOL_AVG / POOL_MAX
//   kernel_size    : K1/K2/K4, anything else acts as K1
//   tile_rows      : input beats per tile (0 acts as 1)
//   in_valid/in_ready/in_data/validity_mask : input row stream
//   out_valid/out_ready/out_data/out_mask   : pooled row stream
//   done_pool      : pulse with the tile's last output handshake (1 in bypass)
//   dbg_state      : current control state
//
// Handshake: a beat moves on either side exactly in a cycle where valid and
// ready are both high; valid never depends on ready, and the output holds
// data/mask steady while out_valid & !out_ready. In pool mode
// in_ready = !out_valid | out_ready, so a new beat may enter in the same
// cycle the held result leaves.
//
// Config (kernel, mode, rows) is sampled by the first beat of a tile and
// held until the tile closes; the first beat itself is processed with the
// live inputs, later beats with the latched copy.
module pool_stream
  import pool_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int DWIDTH = 8,
  parameter int ROWS_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable_pool,
  input  logic                      mode,
  input  logic [2:0]                kernel_size,
  input  logic [ROWS_W-1:0]         tile_rows,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DWIDTH-1:0]   in_data,
  input  logic [LANES-1:0]          validity_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DWIDTH-1:0]   out_data,
  output logic [LANES-1:0]          out_mask,
  output logic                      done_pool,
  output pool_state_e               dbg_state
);

  localparam int AW = DWIDTH + 4;
  localparam int RW = DWIDTH + $clog2(KMAX);

  pool_state_e state, state_next;

  // Latched tile configuration.
  logic [1:0]          cfg_klog2;
  logic                cfg_mode;
  logic [ROWS_W-1:0]   cfg_rows;

  // Tile progress.
  logic                hold_last;   // held result is the tile's final one
  logic [ROWS_W-1:0]   row_cnt;
  logic [1:0]          grp_cnt;

  // Output register.
  logic                     pool_valid;
  logic [LANES*DWIDTH-1:0]  pool_data;
  logic [LANES-1:0]         pool_mask;

  // Effective configuration for the beat currently presented.
  logic                in_tile;
  logic [1:0]          eff_klog2;
  logic                eff_mode;
  logic [ROWS_W-1:0]   eff_rows;
  logic [ROWS_W-1:0]   req_rows;

  logic pool_ready, accept, out_take;
  logic last_row, grp_last, group_end;

  logic [LANES*DWIDTH-1:0]  res_data;
  logic [LANES-1:0]         res_mask;

  // A tile is open once its first beat is in and until its last result is
  // taken; between tiles the live config inputs apply.
  assign in_tile   = (state == ACCUM) || ((state == HOLD) && !hold_last);
  assign req_rows  = (tile_rows == '0) ? ROWS_W'(1) : tile_rows;
  assign eff_klog2 = in_tile ? cfg_klog2 : k_log2(kernel_size);
  assign eff_mode  = in_tile ? cfg_mode  : mode;
  assign eff_rows  = in_tile ? cfg_rows  : req_rows;

  assign pool_ready = !pool_valid || out_ready;
  assign accept     = enable_pool && in_valid && pool_ready;
  assign out_take   = pool_valid && out_ready;

  assign last_row = ((row_cnt + ROWS_W'(1)) == eff_rows);

  always_comb begin
    grp_last = 1'b1;
    case (eff_klog2)
      2'd1:    grp_last = (grp_cnt == 2'd1);
      2'd2:    grp_last = (grp_cnt == 2'd3);
      default: grp_last = 1'b1;
    endcase
  end

  assign group_end = accept && (last_row || grp_last);

  // Per output lane: gather its horizontal window, reduce it, and fold the
  // result into the vertical accumulator.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [KMAX*DWIDTH-1:0] win_data;
    logic [KMAX-1:0]        win_mask;
    logic [RW-1:0]          red_val;
    logic                   red_mask;
    logic                   lane_used;
    logic [AW-1:0]          acc_q, acc_upd;
    logic                   mask_q, mask_upd;
    logic [DWIDTH-1:0]      lane_res;
    logic                   lane_mask;
    int                     base;

    always_comb begin
      win_data = '0;
      win_mask = '0;
      base     = j << eff_klog2;
      for (int i = 0; i < KMAX; i++) begin
        if ((i < (1 << eff_klog2)) && ((base + i) < LANES)) begin
          win_data[i*DWIDTH +: DWIDTH] = in_data[(base + i)*DWIDTH +: DWIDTH];
          win_mask[i]                  = validity_mask[base + i];
        end
      end
    end

    pool_window_reduce #(.DWIDTH(DWIDTH)) u_reduce (
      .win_data (win_data),
      .win_mask (win_mask),
      .mode     (eff_mode),
      .red_val  (red_val),
      .red_mask (red_mask)
    );

    assign lane_used = (j < (LANES >> eff_klog2));

    always_comb begin
      if (eff_mode == POOL_MAX)
        acc_upd = (AW'(red_val) > acc_q) ? AW'(red_val) : acc_q;
      else
        acc_upd = acc_q + AW'(red_val);
      mask_upd  = mask_q | red_mask;
      lane_res  = '0;
      lane_mask = 1'b0;
      if (lane_used) begin
        lane_mask = mask_upd;
        // Average always divides by k*k, so a short final group is
        // implicitly padded with zero rows.
        if (eff_mode == POOL_MAX) lane_res = acc_upd[DWIDTH-1:0];
        else                      lane_res = DWIDTH'(acc_upd >> {eff_klog2, 1'b0});
      end
    end

    always_ff @(posedge clk) begin
      if (reset || !enable_pool) begin
        acc_q  <= '0;
        mask_q <= 1'b0;
      end else if (accept) begin
        if (group_end) begin
          acc_q  <= '0;
          mask_q <= 1'b0;
        end else begin
          acc_q  <= acc_upd;
          mask_q <= mask_upd;
        end
      end
    end

    assign res_data[j*DWIDTH +: DWIDTH] = lane_res;
    assign res_mask[j]                  = lane_mask;
  end

  // FSM state register; dropping enable_pool aborts the tile like a reset.
  always_ff @(posedge clk) begin
    if (reset || !enable_pool) state <= IDLE;
    else                       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (group_end)     state_next = HOLD;
    else if (accept)   state_next = ACCUM;
    else if (out_take) state_next = hold_last ? IDLE : ACCUM;
  end

  // Config latch, counters and output register.
  always_ff @(posedge clk) begin
    if (reset || !enable_pool) begin
      cfg_klog2  <= '0;
      cfg_mode   <= POOL_AVG;
      cfg_rows   <= '0;
      hold_last  <= 1'b0;
      row_cnt    <= '0;
      grp_cnt    <= '0;
      pool_valid <= 1'b0;
      pool_data  <= '0;
      pool_mask  <= '0;
    end else begin
      if (accept && !in_tile) begin
        cfg_klog2 <= k_log2(kernel_size);
        cfg_mode  <= mode;
        cfg_rows  <= req_rows;
      end
      if (accept) begin
        if (group_end) begin
          grp_cnt   <= '0;
          row_cnt   <= last_row ? '0 : row_cnt + 1'b1;
          pool_data <= res_data;
          pool_mask <= res_mask;
          hold_last <= last_row;
        end else begin
          grp_cnt <= grp_cnt + 2'd1;
          row_cnt <= row_cnt + 1'b1;
        end
      end
      if (group_end)     pool_valid <= 1'b1;
      else if (out_take) pool_valid <= 1'b0;
    end
  end

  // Bypass muxing.
  assign in_ready  = enable_pool ? pool_ready : out_ready;
  assign out_valid = enable_pool ? pool_valid : in_valid;
  assign out_data  = enable_pool ? pool_data  : in_data;
  assign out_mask  = enable_pool ? pool_mask  : validity_mask;
  assign done_pool = enable_pool ? (out_take && hold_last) : 1'b1;
  assign dbg_state = state;

endmodule

// File: tb/tb_pool_stream.sv
// Testbench for pool_stream: directed scenarios plus randomized tiles,
// checked against a per-tile arithmetic reference model.
module tb_pool_stream;
  import pool_pkg::*;

  localparam int LANES  = 8;
  localparam int DWIDTH = 8;
  localparam int ROWS_W = 16;
  localparam int DW     = LANES * DWIDTH;

  logic              clk;
  logic              reset;
  logic              enable_pool;
  logic              mode;
  logic [2:0]        kernel_size;
  logic [ROWS_W-1:0] tile_rows;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [LANES-1:0]  validity_mask;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [LANES-1:0]  out_mask;
  logic              done_pool;
  pool_state_e       dbg_state;

  pool_stream #(.LANES(LANES), .DWIDTH(DWIDTH), .ROWS_W(ROWS_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_pool   (enable_pool),
    .mode          (mode),
    .kernel_size   (kernel_size),
    .tile_rows     (tile_rows),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .validity_mask (validity_mask),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_mask      (out_mask),
    .done_pool     (done_pool),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]    exp_q[$];
  logic [LANES-1:0] exp_mask_q[$];
  bit               exp_last_q[$];

  logic [DW-1:0]    beat_data[16];
  logic [LANES-1:0] beat_mask[16];

  int rdy_mode = 1;  // 0 random, 1 high, 2 low, 3 driven by hand
  bit mon_en   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pools a whole tile from beat_data/beat_mask into expected results.
  task automatic model_tile(input int kcode, input bit md, input int rows);
    int k, n, ng, s, mx, v, ln;
    bit mk;
    logic [DW-1:0]    od;
    logic [LANES-1:0] om;
    k  = (kcode == 2) ? 2 : (kcode == 4) ? 4 : 1;
    n  = (rows == 0) ? 1 : rows;
    ng = (n + k - 1) / k;
    for (int g = 0; g < ng; g++) begin
      od = '0;
      om = '0;
      for (int j = 0; j < LANES / k; j++) begin
        s = 0; mx = 0; mk = 0;
        for (int r = g * k; r < g * k + k && r < n; r++) begin
          for (int i = 0; i < k; i++) begin
            ln = j * k + i;
            if (beat_mask[r][ln]) begin
              v  = int'(beat_data[r][ln*DWIDTH +: DWIDTH]);
              s  = s + v;
              if (v > mx) mx = v;
              mk = 1;
            end
          end
        end
        od[j*DWIDTH +: DWIDTH] = md ? DWIDTH'(mx) : DWIDTH'(s / (k * k));
        om[j] = mk;
      end
      exp_q.push_back(od);
      exp_mask_q.push_back(om);
      exp_last_q.push_back(g == ng - 1);
    end
  endtask

  // ---------------- output side ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      2:       out_ready = 1'b0;
      default: ;
    endcase
  end

  always @(negedge clk) begin
    bit hs;
    bit exp_done;
    if (mon_en && !reset && enable_pool) begin
      hs       = out_valid && out_ready;
      exp_done = 1'b0;
      check_val("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (hs) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 64'(1), 64'(0));
        end else begin
          check_val("out_data", out_data, exp_q[0]);
          check_val("out_mask", 64'(out_mask), 64'(exp_mask_q[0]));
          exp_done = exp_last_q[0];
          void'(exp_q.pop_front());
          void'(exp_mask_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
      check_val("done_pool", 64'(done_pool), 64'(exp_done));
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic drive_beat(input logic [DW-1:0] d, input logic [LANES-1:0] m, input bit gaps);
    int idle;
    bit took;
    idle = gaps ? $urandom_range(0, 2) : 0;
    in_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    in_valid      = 1'b1;
    in_data       = d;
    validity_mask = m;
    took          = 1'b0;
    for (int c = 0; c < 200 && !took; c++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    if (!took) check_val("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drive_tile(input int kcode, input bit md, input int rows, input bit gaps);
    int n;
    kernel_size = 3'(kcode);
    mode        = md;
    tile_rows   = ROWS_W'(rows);
    model_tile(kcode, md, rows);
    n = (rows == 0) ? 1 : rows;
    for (int r = 0; r < n; r++) begin
      drive_beat(beat_data[r], beat_mask[r], gaps);
      if (r == 0) begin
        // mid-tile config changes must be ignored
        kernel_size = 3'($urandom_range(0, 7));
        mode        = 1'($urandom_range(0, 1));
        tile_rows   = ROWS_W'($urandom_range(0, 9));
      end
    end
  endtask

  task automatic fill_const(input int r, input logic [DWIDTH-1:0] v, input logic [LANES-1:0] m);
    beat_data[r] = {LANES{v}};
    beat_mask[r] = m;
  endtask

  task automatic fill_random(input int n);
    for (int r = 0; r < n; r++) begin
      for (int ln = 0; ln < LANES; ln++)
        beat_data[r][ln*DWIDTH +: DWIDTH] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      beat_mask[r] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 500 && exp_q.size() > 0; c++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() > 0) check_val("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; enable_pool = 1'b1; mode = 1'b0; kernel_size = 3'd1; tile_rows = '0;
    in_valid = 1'b0; in_data = '0; validity_mask = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset values
    @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_out_data",  out_data,       64'(0));
    check_val("rst_out_mask",  64'(out_mask),  64'(0));
    check_val("rst_done_pool", 64'(done_pool), 64'(0));
    check_val("rst_in_ready",  64'(in_ready),  64'(1));
    check_val("rst_state",     64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    mon_en = 1'b1;

    // k=2 avg, 10 then 30
    fill_const(0, 8'd10, 8'hFF); fill_const(1, 8'd30, 8'hFF);
    drive_tile(2, 1'b0, 2, 1'b0);
    // k=4 max with one large element
    for (int r = 0; r < 4; r++) fill_const(r, 8'd1, 8'hFF);
    beat_data[3][5*DWIDTH +: DWIDTH] = 8'd200;
    drive_tile(4, 1'b1, 4, 1'b0);
    // k=2 avg with lane 0 masked
    fill_const(0, 8'd100, 8'hFE); fill_const(1, 8'd100, 8'hFE);
    drive_tile(2, 1'b0, 2, 1'b0);
    // k=2, partial final group
    for (int r = 0; r < 3; r++) fill_const(r, 8'd40, 8'hFF);
    drive_tile(2, 1'b0, 3, 1'b0);
    wait_drain();

    // k=1 with downstream stalled for 3 cycles
    rdy_mode = 2; out_ready = 1'b0;
    fill_random(4);
    kernel_size = 3'd1; mode = 1'b0; tile_rows = ROWS_W'(4);
    model_tile(1, 1'b0, 4);
    drive_beat(beat_data[0], beat_mask[0], 1'b0);
    in_valid = 1'b1; in_data = beat_data[1]; validity_mask = beat_mask[1];
    repeat (3) begin
      @(negedge clk);
      check_val("hold_valid",    64'(out_valid), 64'(1));
      check_val("hold_in_ready", 64'(in_ready),  64'(0));
      check_val("hold_data",     out_data,       exp_q[0]);
      @(posedge clk); #1;
    end
    rdy_mode = 1; out_ready = 1'b1;
    for (int r = 1; r < 4; r++) drive_beat(beat_data[r], beat_mask[r], 1'b0);
    wait_drain();

    // bypass
    enable_pool = 1'b0; rdy_mode = 3;
    repeat (8) begin
      in_data       = {$urandom, $urandom};
      validity_mask = 8'($urandom_range(0, 255));
      in_valid      = 1'($urandom_range(0, 1));
      out_ready     = 1'($urandom_range(0, 1));
      #1;
      check_val("byp_data",  out_data,         in_data);
      check_val("byp_mask",  64'(out_mask),    64'(validity_mask));
      check_val("byp_valid", 64'(out_valid),   64'(in_valid));
      check_val("byp_ready", 64'(in_ready),    64'(out_ready));
      check_val("byp_done",  64'(done_pool),   64'(1));
      @(posedge clk); #1;
    end
    check_val("byp_state", 64'(dbg_state), 64'(IDLE));
    in_valid = 1'b0; enable_pool = 1'b1; rdy_mode = 1; out_ready = 1'b1;
    @(posedge clk); #1;

    // reset with a result pending
    rdy_mode = 2; out_ready = 1'b0;
    kernel_size = 3'd2; mode = 1'b0; tile_rows = ROWS_W'(4);
    fill_random(2);
    drive_beat(beat_data[0], beat_mask[0], 1'b0);
    drive_beat(beat_data[1], beat_mask[1], 1'b0);
    @(negedge clk);
    check_val("pre_rst_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("mid_rst_valid", 64'(out_valid), 64'(0));
    check_val("mid_rst_data",  out_data,       64'(0));
    check_val("mid_rst_mask",  64'(out_mask),  64'(0));
    check_val("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    rdy_mode = 0;
    fill_random(4);
    drive_tile(2, 1'b0, 4, 1'b1);
    wait_drain();

    // enable_pool dropped mid-group
    rdy_mode = 1; out_ready = 1'b1;
    kernel_size = 3'd4; mode = 1'b0; tile_rows = ROWS_W'(4);
    fill_random(2);
    drive_beat(beat_data[0], beat_mask[0], 1'b0);
    drive_beat(beat_data[1], beat_mask[1], 1'b0);
    enable_pool = 1'b0;
    @(posedge clk); #1;
    enable_pool = 1'b1;
    check_val("drop_state", 64'(dbg_state), 64'(IDLE));
    fill_random(4);
    drive_tile(4, 1'b0, 4, 1'b0);
    wait_drain();

    // randomized tiles
    rdy_mode = 0;
    repeat (40) begin
      int kc, rw;
      bit md;
      kc = $urandom_range(0, 7);
      md = 1'($urandom_range(0, 1));
      rw = $urandom_range(0, 7);
      fill_random((rw == 0) ? 1 : rw);
      drive_tile(kc, md, rw, 1'b1);
    end
    rdy_mode = 1;
    wait_drain();
    check_val("leftover", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
